ser_bit_feeder: RTL

SER_BIT_FEEDER -- requirements
Module: ser_bit_feeder

---
 rtl/ser_bit_feeder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ser_bit_feeder.sv
// Parallel-to-serial bit feeder: one-word holding register in front of a shifter, gapless back-to-back output.
// Optional build macro SER_PARITY_EN appends an even-parity bit after each word.
module ser_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             word_done_q, word_done_d;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic          load_shift;
  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic          first_bit;
  logic          next_bit;

  // cnt_q is the index of the bit currently presented on x
  assign cnt_inc    = cnt_q + CW'(1);
  assign load_shift = hold_full_q & ((state_q == IDLE) | (cnt_q == LAST_C));
  assign in_ready   = (!hold_full_q | load_shift) & !rst;
  assign accept     = in_valid & in_ready;
  assign first_bit  = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];

  always_comb begin
    next_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
`ifdef SER_PARITY_EN
    if (cnt_inc == CW'(WIDTH)) next_bit = parity_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    x_d         = 1'b0;
    x_valid_d   = 1'b0;
    word_done_d = 1'b0;
`ifdef SER_PARITY_EN
    parity_d    = parity_q;
`endif

    if (load_shift) begin
      state_d   = SHIFT;
      shreg_d   = MSB_FIRST ? (hold_q << 1) : (hold_q >> 1);
      cnt_d     = '0;
      x_d       = first_bit;
      x_valid_d = 1'b1;
`ifdef SER_PARITY_EN
      parity_d  = ^hold_q;
`endif
      hold_full_d = 1'b0;
    end else if (state_q == SHIFT && cnt_q != LAST_C) begin
      shreg_d     = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
      cnt_d       = cnt_inc;
      x_d         = next_bit;
      x_valid_d   = 1'b1;
      word_done_d = (cnt_inc == LAST_C);
    end else if (state_q == SHIFT) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    // a word accepted during a reload lands in hold behind the one just moved out
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      x_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign word_done = word_done_q;
  assign busy      = (state_q == SHIFT) | hold_full_q;

endmodule
